cache_axi_bridge: RTL and testbench
===================================

# cache_axi_bridge

Converts the data cache's miss-side request interface (cache-line or single-word reads and writes) into AXI4 master transactions on a 32-bit bus. It sits directly downstream of the data cache: it consumes `rd_req`/`wr_req` and returns refill beats via `ret_valid`/`ret_last`/`ret_data`. One read and one write may be outstanding concurrently. A read whose line matches a still-pending write is held off until that write's response arrives.

## Interface
Parameters:
- `RD_ID`, default 4'd0: ARID for all reads.
- `WR_ID`, default 4'd1: AWID/WID for all writes.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `rd_req`  in  1  read request; held until accepted.
- `rd_type`  in  3  3'b010 single word, 3'b100 line (4 words).
- `rd_addr`  in  32  read address; line reads are 16-byte aligned.
- `rd_rdy`  out  1  read accept; handshake is `rd_req && rd_rdy`.
- `ret_valid`  out  1  one returned read beat.
- `ret_last`  out  1  last returned beat.
- `ret_data`  out  32  beat data.
- `wr_req`  in  1  single-cycle write pulse; the cache only raises it while `wr_rdy` = 1.
- `wr_type`  in  3  encoding as `rd_type`.
- `wr_addr`  in  32  write address.
- `wr_wstrb`  in  4  byte strobe for word writes.
- `wr_data`  in  128  line data (word i at [32i+31:32i]).
- `wr_rdy`  out  1  write buffer empty.
- `arid`/`araddr`/`arlen`/`arsize`/`arburst`/`arvalid`  out  4/32/8/3/2/1; `arready`  in  1.
- `rid`/`rdata`/`rresp`/`rlast`/`rvalid`  in  4/32/2/1/1; `rready`  out  1.
- `awid`/`awaddr`/`awlen`/`awsize`/`awburst`/`awvalid`  out  4/32/8/3/2/1; `awready`  in  1.
- `wid`/`wdata`/`wstrb`/`wlast`/`wvalid`  out  4/32/4/1/1; `wready`  in  1.
- `bid`/`bresp`/`bvalid`  in  4/2/1; `bready`  out  1.

## Operation
Read FSM: R_IDLE → R_AR → R_DATA → R_IDLE.
- R_IDLE:
  - `rd_rdy` = !reset && !conflict.
  - `conflict` = write FSM not in W_IDLE && `rd_addr[31:4]` == `wbuf_addr[31:4]`.
  - On handshake: latch address and type, go to R_AR.
- R_AR:
  - `arvalid` = 1; `araddr` is the latched address.
  - `arlen` = 3 for a line, 0 for a word; `arsize` = 3'b010; `arburst` = 2'b01 (INCR); `arid` = RD_ID.
  - Leave on `arready`.
- R_DATA:
  - `rready` = 1; `ret_valid` = `rvalid`; `ret_data` = `rdata`; `ret_last` = `rvalid && rlast`.
  - On `rvalid && rlast`, return to R_IDLE.
  - `rresp` and `rid` are ignored.

Write FSM: W_IDLE → W_AW → W_DATA → W_B → W_IDLE.
- W_IDLE:
  - `wr_rdy` = !reset.
  - On `wr_req`: latch `wbuf_addr`, `wbuf_type`, `wbuf_strb`, and `wbuf_data` (128 bits); clear beat counter `wcnt` (2 bits); go to W_AW.
- W_AW:
  - `awvalid` = 1; `awlen` = 3 for a line, 0 for a word; `awsize` = 3'b010; `awburst` = 2'b01.
  - `awaddr` = `wbuf_addr` for a word; {`wbuf_addr[31:4]`, 4'b0} for a line.
  - Leave on `awready`.
- W_DATA:
  - `wvalid` = 1.
  - Line: `wdata` = `wbuf_data[32*wcnt +: 32]`; `wstrb` = 4'hF; `wlast` = (`wcnt` == 3).
  - Word: `wdata` = `wbuf_data[32*wbuf_addr[3:2] +: 32]`; `wstrb` = `wbuf_strb`; `wlast` = 1.
  - On `wready`: `wcnt` += 1; on `wready && wlast`, go to W_B.
- W_B: `bready` = 1; on `bvalid`, go to W_IDLE. `bresp` is ignored.

Boundary rules:
- A `wr_req` while not in W_IDLE is a protocol violation. It is ignored, and the assertion `wr_req |-> write FSM in W_IDLE` fires.
- Read and write FSMs run independently. Simultaneous `rd_req` and `wr_req` in one cycle are both accepted only if there is no conflict. The conflict check uses the registered write buffer, so a same-cycle same-line pair is accepted (the cache never issues one).
- `wcnt` wraps 3 → 0 only on the final beat.
- Reset mid-burst: both FSMs return to idle immediately and all valid/ready outputs drop. No AXI cleanup is performed; the system resets the interconnect together with the bridge.

## Timing
- Reset values: all `*valid`, `rready`, `bready`, `ret_*`, `rd_rdy`, and `wr_rdy` are 0. Address and data outputs are 0. Both FSMs are idle.
- Read handshake at cycle t → `arvalid` at t+1. First `ret_valid` is in the same cycle as the first `rvalid` (combinational pass-through; no buffering).
- `wr_req` at cycle t → `awvalid` at t+1. First `wvalid` in the cycle after `awready`. One beat per `wready` cycle.
- `wr_rdy` returns 1 in the cycle after `bvalid`. A conflicting read becomes acceptable in that same cycle.
- `arvalid`/`awvalid`/`wvalid` and their payloads stay stable until accepted.

## Structure
- Package `cache_axi_pkg`:
  - `RD_WORD` = 3'b010, `RD_LINE` = 3'b100.
  - `AXI_INCR` = 2'b01, `AXI_SIZE4` = 3'b010.
  - Read and write FSM state enums.
- Sub-module `axi_wr_engine`: write buffer plus the W_* FSM. It exports `busy` and the buffered line address for the conflict check. The read path stays in the top module.

## Test plan
- Line read to 0x1C00_0040, `arready` immediate, R beats 0xA0..0xA3 with one gap cycle → `araddr` 0x1C00_0040, `arlen` 3; four `ret_valid` pulses with data in order; `ret_last` only with 0xA3.
- Word write to 0xBFAF_8008, `wr_wstrb` 4'b0011, `wr_data` word2 = 0x1234_5678 → `awlen` 0; a single beat with `wdata` 0x1234_5678, `wstrb` 4'b0011, `wlast` 1; `wr_rdy` high again the cycle after `bvalid`.
- Line write to 0x0000_1230, `wready` toggling every other cycle → `awaddr` 0x0000_1230; 4 beats in word order 0..3; `wlast` only on beat 3; `wvalid`/`wdata` held during stalls.
- Pending write to line 0x0000_2000 with `bvalid` delayed 10 cycles, then `rd_req` to 0x0000_2008 → `rd_rdy` = 0 until the cycle after `bvalid`; `arvalid` only afterwards. A read to 0x0000_3000 in the same window is accepted immediately.
- Reset asserted during the second R beat of a line read → the next cycle has all outputs at reset values; a new line read afterwards completes normally with 4 beats.

Source files
------------

// File: rtl/cache_axi_bridge_pkg.sv
// Shared definitions for the cache-to-AXI4 bridge.
//   - cache request type encodings (word / 4-word line)
//   - fixed AXI burst attributes for a 32-bit bus
//   - read and write FSM state enums
//   - burst_len(): AXI LEN field for a cache request type
package cache_axi_pkg;

  localparam logic [2:0] RD_WORD   = 3'b010;
  localparam logic [2:0] RD_LINE   = 3'b100;
  localparam logic [1:0] AXI_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE4 = 3'b010;

  typedef enum logic [1:0] {
    RIdle,
    RAr,
    RData
  } rd_state_e;

  typedef enum logic [1:0] {
    WIdle,
    WAw,
    WData,
    WB
  } wr_state_e;

  // A line is four 32-bit beats; anything else is a single beat.
  function automatic logic [7:0] burst_len(input logic [2:0] req_type);
    return (req_type == RD_LINE) ? 8'd3 : 8'd0;
  endfunction

endpackage

// File: rtl/cache_axi_bridge_if.sv
// Bundle of the cache miss-side request/return signals and the AXI4 master channels.
//   master: bridge view (consumes cache requests, drives AXI AR/AW/W, RREADY/BREADY)
//   slave : environment view (cache plus AXI interconnect)
interface cache_axi_bridge_if;

  // Cache read side
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;
  // Cache write side
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;
  // AXI AR
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  // AXI R
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  // AXI AW
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready;
  // AXI W
  logic [3:0]   wid;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  // AXI B
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;

  modport master (
    input  rd_req, rd_type, rd_addr,
    output rd_rdy, ret_valid, ret_last, ret_data,
    input  wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    output wr_rdy,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    output rd_req, rd_type, rd_addr,
    input  rd_rdy, ret_valid, ret_last, ret_data,
    output wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    input  wr_rdy,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/cache_axi_bridge_wr_engine.sv
// Write buffer plus AW/W/B sequencing for the cache-to-AXI bridge.
// One write in flight: the cache request is captured whole in W_IDLE, then issued as an
// AW beat, 1 or 4 W beats and a B wait.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   wr_*_i / wr_rdy_o     cache write request and buffer-empty indication
//   aw*_o / awready_i     AXI AW channel
//   w*_o / wready_i       AXI W channel
//   bvalid_i / bready_o   AXI B channel (id/resp are not needed here)
//   busy_o, wbuf_line_o   buffer occupied and its line address, for read hazard checks
module axi_wr_engine
  import cache_axi_pkg::*;
#(
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_req_i,
  input  logic [2:0]   wr_type_i,
  input  logic [31:0]  wr_addr_i,
  input  logic [3:0]   wr_wstrb_i,
  input  logic [127:0] wr_data_i,
  output logic         wr_rdy_o,
  output logic [3:0]   awid_o,
  output logic [31:0]  awaddr_o,
  output logic [7:0]   awlen_o,
  output logic [2:0]   awsize_o,
  output logic [1:0]   awburst_o,
  output logic         awvalid_o,
  input  logic         awready_i,
  output logic [3:0]   wid_o,
  output logic [31:0]  wdata_o,
  output logic [3:0]   wstrb_o,
  output logic         wlast_o,
  output logic         wvalid_o,
  input  logic         wready_i,
  input  logic         bvalid_i,
  output logic         bready_o,
  output logic         busy_o,
  output logic [27:0]  wbuf_line_o
);

  wr_state_e    state_q, state_d;
  logic [31:0]  addr_q;
  logic [2:0]   type_q;
  logic [3:0]   strb_q;
  logic [127:0] data_q;
  logic [1:0]   wcnt_q;

  logic       is_line;
  logic       last_beat;
  logic [1:0] word_sel;

  assign is_line     = (type_q == RD_LINE);
  assign last_beat   = is_line ? (wcnt_q == 2'd3) : 1'b1;
  // Line bursts walk the buffer; a word write sends the word its address points at.
  assign word_sel    = is_line ? wcnt_q : addr_q[3:2];
  assign busy_o      = (state_q != WIdle);
  assign wbuf_line_o = addr_q[31:4];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WIdle:   if (wr_req_i)              state_d = WAw;
      WAw:     if (awready_i)             state_d = WData;
      WData:   if (wready_i && last_beat) state_d = WB;
      WB:      if (bvalid_i)              state_d = WIdle;
      default:                            state_d = WIdle;
    endcase
  end

  // Buffer capture and beat counter; wcnt wraps 3 -> 0 only on the final line beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      type_q <= '0;
      strb_q <= '0;
      data_q <= '0;
      wcnt_q <= '0;
    end else if (state_q == WIdle && wr_req_i) begin
      addr_q <= wr_addr_i;
      type_q <= wr_type_i;
      strb_q <= wr_wstrb_i;
      data_q <= wr_data_i;
      wcnt_q <= '0;
    end else if (state_q == WData && wready_i) begin
      wcnt_q <= wcnt_q + 2'd1;
    end
  end

  always_comb begin
    wr_rdy_o  = 1'b0;
    awid_o    = '0;
    awaddr_o  = '0;
    awlen_o   = '0;
    awsize_o  = '0;
    awburst_o = '0;
    awvalid_o = 1'b0;
    wid_o     = '0;
    wdata_o   = '0;
    wstrb_o   = '0;
    wlast_o   = 1'b0;
    wvalid_o  = 1'b0;
    bready_o  = 1'b0;
    unique case (state_q)
      WIdle: wr_rdy_o = !reset;
      WAw: begin
        awvalid_o = 1'b1;
        awid_o    = WR_ID;
        awaddr_o  = is_line ? {addr_q[31:4], 4'b0} : addr_q;
        awlen_o   = burst_len(type_q);
        awsize_o  = AXI_SIZE4;
        awburst_o = AXI_INCR;
      end
      WData: begin
        wvalid_o = 1'b1;
        wid_o    = WR_ID;
        wdata_o  = data_q[{word_sel, 5'b0} +: 32];
        wstrb_o  = is_line ? 4'hF : strb_q;
        wlast_o  = last_beat;
      end
      WB:      bready_o = 1'b1;
      default: ;
    endcase
  end

  // The cache must only pulse wr_req while wr_rdy is high.
  wr_req_only_when_idle_a: assert property (@(posedge clk) disable iff (reset)
    wr_req_i |-> (state_q == WIdle));

endmodule

// File: rtl/cache_axi_bridge.sv
// Converts data-cache miss requests into AXI4 master transactions on a 32-bit bus.
// The read path (AR/R) lives here; the write path is axi_wr_engine. One read and one write
// may be outstanding together; a read to the line held in the write buffer waits until
// that write's B response has been taken.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   bus_io      cache request/return signals and AXI channels (master view)
module cache_axi_bridge
  import cache_axi_pkg::*;
#(
  parameter logic [3:0] RD_ID = 4'd0,
  parameter logic [3:0] WR_ID = 4'd1
) (
  input logic                  clk,
  input logic                  reset,
  cache_axi_bridge_if.master   bus_io
);

  rd_state_e   rstate_q, rstate_d;
  logic [31:0] raddr_q;
  logic [2:0]  rtype_q;

  logic        wr_busy;
  logic [27:0] wbuf_line;
  logic        conflict;
  logic        rd_rdy;
  logic        rd_fire;

  // Compared against the registered buffer, so a same-cycle write to the line is not seen.
  assign conflict = wr_busy && (bus_io.rd_addr[31:4] == wbuf_line);
  assign rd_rdy   = (rstate_q == RIdle) && !reset && !conflict;
  assign rd_fire  = bus_io.rd_req && rd_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      rstate_q <= RIdle;
    end else begin
      rstate_q <= rstate_d;
    end
  end

  always_comb begin
    rstate_d = rstate_q;
    unique case (rstate_q)
      RIdle:   if (rd_fire)                        rstate_d = RAr;
      RAr:     if (bus_io.arready)                 rstate_d = RData;
      RData:   if (bus_io.rvalid && bus_io.rlast)  rstate_d = RIdle;
      default:                                     rstate_d = RIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      raddr_q <= '0;
      rtype_q <= '0;
    end else if (rd_fire) begin
      raddr_q <= bus_io.rd_addr;
      rtype_q <= bus_io.rd_type;
    end
  end

  // R beats pass straight through to the cache with no buffering.
  always_comb begin
    bus_io.rd_rdy    = rd_rdy;
    bus_io.arid      = '0;
    bus_io.araddr    = '0;
    bus_io.arlen     = '0;
    bus_io.arsize    = '0;
    bus_io.arburst   = '0;
    bus_io.arvalid   = 1'b0;
    bus_io.rready    = 1'b0;
    bus_io.ret_valid = 1'b0;
    bus_io.ret_last  = 1'b0;
    bus_io.ret_data  = '0;
    unique case (rstate_q)
      RAr: begin
        bus_io.arvalid = 1'b1;
        bus_io.arid    = RD_ID;
        bus_io.araddr  = raddr_q;
        bus_io.arlen   = burst_len(rtype_q);
        bus_io.arsize  = AXI_SIZE4;
        bus_io.arburst = AXI_INCR;
      end
      RData: begin
        bus_io.rready    = 1'b1;
        bus_io.ret_valid = bus_io.rvalid;
        bus_io.ret_last  = bus_io.rvalid && bus_io.rlast;
        bus_io.ret_data  = bus_io.rdata;
      end
      default: ;
    endcase
  end

  // Response id/status carry nothing the cache can act on.
  logic unused_resp;
  assign unused_resp = ^{bus_io.rid, bus_io.rresp, bus_io.bid, bus_io.bresp};

  axi_wr_engine #(
    .WR_ID (WR_ID)
  ) u_wr_engine (
    .clk         (clk),
    .reset       (reset),
    .wr_req_i    (bus_io.wr_req),
    .wr_type_i   (bus_io.wr_type),
    .wr_addr_i   (bus_io.wr_addr),
    .wr_wstrb_i  (bus_io.wr_wstrb),
    .wr_data_i   (bus_io.wr_data),
    .wr_rdy_o    (bus_io.wr_rdy),
    .awid_o      (bus_io.awid),
    .awaddr_o    (bus_io.awaddr),
    .awlen_o     (bus_io.awlen),
    .awsize_o    (bus_io.awsize),
    .awburst_o   (bus_io.awburst),
    .awvalid_o   (bus_io.awvalid),
    .awready_i   (bus_io.awready),
    .wid_o       (bus_io.wid),
    .wdata_o     (bus_io.wdata),
    .wstrb_o     (bus_io.wstrb),
    .wlast_o     (bus_io.wlast),
    .wvalid_o    (bus_io.wvalid),
    .wready_i    (bus_io.wready),
    .bvalid_i    (bus_io.bvalid),
    .bready_o    (bus_io.bready),
    .busy_o      (wr_busy),
    .wbuf_line_o (wbuf_line)
  );

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Self-checking bench for cache_axi_bridge: background AXI slave responders, a negedge
// monitor popping scoreboard queues, and directed scenarios for reads, writes, the
// read-after-write hazard and reset mid-burst.
module tb_cache_axi_bridge;
  import cache_axi_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_axi_bridge_if bus ();

  cache_axi_bridge #(
    .RD_ID (4'd0),
    .WR_ID (4'd1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ret_seen = 0;
  int b_done   = 0;
  int b_cyc    = 0;
  int b_delay  = 0;
  bit r_gap    = 0;
  bit w_toggle = 0;
  logic [31:0] r_base = 32'h0;

  logic [32:0] r_q [$];   // {last, data}
  logic [39:0] ar_q[$];   // {addr, len}
  logic [39:0] aw_q[$];   // {addr, len}
  logic [36:0] w_q [$];   // {data, strb, last}

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // R responder: after each AR handshake return arlen+1 beats of r_base+i.
  initial begin : r_slave
    int n;
    int k;
    bit abort;
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    bus.rdata  = '0;
    bus.rid    = '0;
    bus.rresp  = '0;
    forever begin
      @(negedge clk);
      if (!reset && bus.arvalid && bus.arready) begin
        n = int'(bus.arlen) + 1;
        abort = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
          if (r_gap && i == 1) begin
            @(posedge clk);
            #1;
          end
          bus.rvalid = 1'b1;
          bus.rdata  = r_base + 32'(i);
          bus.rlast  = (i == n - 1);
          r_q.push_back({bus.rlast, bus.rdata});
          k = 0;
          @(negedge clk);
          while (!bus.rready && !reset && k < 50) begin
            k++;
            @(negedge clk);
          end
          if (reset) begin
            abort = 1'b1;
          end else if (!bus.rready) begin
            check("rready_timeout", 64'(bus.rready), 64'd1);
            abort = 1'b1;
          end
          if (abort) break;
          @(posedge clk);
          #1;
          bus.rvalid = 1'b0;
          bus.rlast  = 1'b0;
        end
        if (abort) begin
          bus.rvalid = 1'b0;
          bus.rlast  = 1'b0;
          r_q.delete();
        end
      end
    end
  end

  // B responder: b_delay cycles after the last W beat, offer one response.
  initial begin : b_slave
    int k;
    bus.bvalid = 1'b0;
    bus.bid    = 4'd1;
    bus.bresp  = '0;
    forever begin
      @(negedge clk);
      if (!reset && bus.wvalid && bus.wready && bus.wlast) begin
        @(posedge clk);
        #1;
        repeat (b_delay) begin
          @(posedge clk);
          #1;
        end
        bus.bvalid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!bus.bready && k < 50) begin
          k++;
          @(negedge clk);
        end
        check("bready_seen", 64'(bus.bready), 64'd1);
        check("wr_rdy_in_b", 64'(bus.wr_rdy), 64'd0);
        b_cyc = cyc;
        b_done++;
        @(posedge clk);
        #1;
        bus.bvalid = 1'b0;
      end
    end
  end

  initial begin : w_ready_gen
    bus.wready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.wready = w_toggle ? ~bus.wready : 1'b1;
    end
  end

  // Monitor: every handshake is checked against the scoreboard.
  initial begin : monitor
    logic [32:0] er;
    logic [39:0] ea;
    logic [36:0] ew;
    logic [37:0] w_hold;
    bit w_stall;
    w_stall = 1'b0;
    w_hold  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        w_stall = 1'b0;
      end else begin
        if (bus.ret_valid) begin
          ret_seen++;
          if (r_q.size() == 0) begin
            check("ret_unexpected", 64'd1, 64'd0);
          end else begin
            er = r_q.pop_front();
            check("ret_data", 64'(bus.ret_data), 64'(er[31:0]));
            check("ret_last", 64'(bus.ret_last), 64'(er[32]));
          end
        end
        if (bus.arvalid && bus.arready) begin
          if (ar_q.size() == 0) begin
            check("ar_unexpected", 64'd1, 64'd0);
          end else begin
            ea = ar_q.pop_front();
            check("araddr", 64'(bus.araddr), 64'(ea[39:8]));
            check("arlen", 64'(bus.arlen), 64'(ea[7:0]));
            check("ar_attr", 64'({bus.arsize, bus.arburst, bus.arid}), 64'({3'b010, 2'b01, 4'd0}));
          end
        end
        if (bus.awvalid && bus.awready) begin
          if (aw_q.size() == 0) begin
            check("aw_unexpected", 64'd1, 64'd0);
          end else begin
            ea = aw_q.pop_front();
            check("awaddr", 64'(bus.awaddr), 64'(ea[39:8]));
            check("awlen", 64'(bus.awlen), 64'(ea[7:0]));
            check("aw_attr", 64'({bus.awsize, bus.awburst, bus.awid}), 64'({3'b010, 2'b01, 4'd1}));
          end
        end
        if (w_stall) begin
          check("w_hold", 64'({bus.wvalid, bus.wdata, bus.wstrb, bus.wlast}), 64'(w_hold));
        end
        if (bus.wvalid && bus.wready) begin
          if (w_q.size() == 0) begin
            check("w_unexpected", 64'd1, 64'd0);
          end else begin
            ew = w_q.pop_front();
            check("wdata", 64'(bus.wdata), 64'(ew[36:5]));
            check("wstrb", 64'(bus.wstrb), 64'(ew[4:1]));
            check("wlast", 64'(bus.wlast), 64'(ew[0]));
            check("wid", 64'(bus.wid), 64'd1);
          end
        end
        w_stall = bus.wvalid && !bus.wready;
        w_hold  = {1'b1, bus.wdata, bus.wstrb, bus.wlast};
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, 64'({bus.rd_rdy, bus.ret_valid, bus.ret_last, bus.wr_rdy, bus.arvalid,
                              bus.rready, bus.awvalid, bus.wvalid, bus.wlast, bus.bready}), 64'd0);
    check({tag, "_ar"}, 64'({bus.araddr, bus.arlen, bus.arsize, bus.arburst, bus.arid}), 64'd0);
    check({tag, "_aw"}, 64'({bus.awaddr, bus.awlen, bus.awsize, bus.awburst, bus.awid}), 64'd0);
    check({tag, "_w"}, 64'({bus.wdata, bus.wstrb, bus.wid}), 64'd0);
    check({tag, "_ret_data"}, 64'(bus.ret_data), 64'd0);
  endtask

  // Hold rd_req until accepted; report wait, acceptance cycle and first-cycle rd_rdy.
  task automatic rd_issue(input logic [31:0] a, input logic [2:0] t, input logic [7:0] len,
                          output int waited, output int acc, output logic first_rdy);
    waited = 0;
    acc    = 0;
    bus.rd_req  = 1'b1;
    bus.rd_addr = a;
    bus.rd_type = t;
    @(negedge clk);
    first_rdy = bus.rd_rdy;
    while (!bus.rd_rdy && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.rd_rdy) begin
      check("rd_accept_timeout", 64'(bus.rd_rdy), 64'd1);
    end else begin
      acc = cyc;
      ar_q.push_back({a, len});
    end
    @(posedge clk);
    #1;
    bus.rd_req = 1'b0;
  endtask

  task automatic wr_issue(input logic [31:0] a, input logic [2:0] t, input logic [3:0] s,
                          input logic [127:0] d);
    int k;
    int idx;
    k = 0;
    @(negedge clk);
    while (!bus.wr_rdy && k < 100) begin
      k++;
      @(negedge clk);
    end
    if (!bus.wr_rdy) begin
      check("wr_rdy_timeout", 64'(bus.wr_rdy), 64'd1);
      return;
    end
    bus.wr_req   = 1'b1;
    bus.wr_addr  = a;
    bus.wr_type  = t;
    bus.wr_wstrb = s;
    bus.wr_data  = d;
    if (t == RD_LINE) begin
      aw_q.push_back({a[31:4], 4'b0, 8'd3});
      for (int i = 0; i < 4; i++) w_q.push_back({d[32*i +: 32], 4'hF, i == 3});
    end else begin
      idx = int'(a[3:2]);
      aw_q.push_back({a, 8'd0});
      w_q.push_back({d[32*idx +: 32], s, 1'b1});
    end
    @(posedge clk);
    #1;
    bus.wr_req = 1'b0;
  endtask

  task automatic wait_ret(input int target);
    int k;
    k = 0;
    while (ret_seen < target && k < 200) begin
      @(posedge clk);
      k++;
    end
    if (ret_seen < target) check("ret_timeout", 64'(ret_seen), 64'(target));
  endtask

  task automatic wait_bdone(input int prev);
    int k;
    k = 0;
    while (b_done == prev && k < 200) begin
      @(posedge clk);
      k++;
    end
    if (b_done == prev) check("b_timeout", 64'(b_done), 64'(prev + 1));
  endtask

  initial begin : main
    int waited;
    int acc;
    int base;
    int prevb;
    logic first_rdy;
    reset        = 1'b1;
    bus.rd_req   = 1'b0;
    bus.rd_type  = RD_WORD;
    bus.rd_addr  = '0;
    bus.wr_req   = 1'b0;
    bus.wr_type  = RD_WORD;
    bus.wr_addr  = '0;
    bus.wr_wstrb = '0;
    bus.wr_data  = '0;
    bus.arready  = 1'b1;
    bus.awready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("init");
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle_rdys", 64'({bus.rd_rdy, bus.wr_rdy}), 64'b11);

    // Line read with one gap between beats.
    r_gap  = 1'b1;
    r_base = 32'hA0;
    base   = ret_seen;
    rd_issue(32'h1C00_0040, RD_LINE, 8'd3, waited, acc, first_rdy);
    wait_ret(base + 4);
    #1;
    r_gap = 1'b0;
    check("line_rd_beats", 64'(ret_seen - base), 64'd4);

    // Word write: only word 2 with the caller's strobes goes out.
    prevb = b_done;
    wr_issue(32'hBFAF_8008, RD_WORD, 4'b0011,
             {32'hDEAD_0003, 32'h1234_5678, 32'hDEAD_0001, 32'hDEAD_0000});
    wait_bdone(prevb);
    #1;
    check("wr_rdy_after_b", 64'(bus.wr_rdy), 64'd1);

    // Line write with wready toggling.
    w_toggle = 1'b1;
    prevb = b_done;
    wr_issue(32'h0000_1230, RD_LINE, 4'h0,
             {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111});
    wait_bdone(prevb);
    #1;
    w_toggle = 1'b0;
    check("line_wr_drained", 64'(w_q.size()), 64'd0);

    // Read-after-write hazard on line 0x2000 with a late B response.
    b_delay = 10;
    prevb   = b_done;
    wr_issue(32'h0000_2000, RD_LINE, 4'h0,
             {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000});
    r_base = 32'h30;
    base   = ret_seen;
    rd_issue(32'h0000_3000, RD_WORD, 8'd0, waited, acc, first_rdy);
    check("other_line_wait", 64'(waited), 64'd0);
    wait_ret(base + 1);
    #1;
    r_base = 32'h20;
    base   = ret_seen;
    rd_issue(32'h0000_2008, RD_WORD, 8'd0, waited, acc, first_rdy);
    check("conflict_block", 64'(first_rdy), 64'd0);
    check("conflict_done_b", 64'(b_done), 64'(prevb + 1));
    check("conflict_release_cyc", 64'(acc), 64'(b_cyc + 1));
    wait_ret(base + 1);
    #1;
    b_delay = 0;

    // Reset during the second beat of a line read.
    r_base = 32'hB0;
    base   = ret_seen;
    rd_issue(32'h0000_5000, RD_LINE, 8'd3, waited, acc, first_rdy);
    wait_ret(base + 1);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midburst");
    reset = 1'b0;
    @(posedge clk);
    #1;
    r_base = 32'hC0;
    base   = ret_seen;
    rd_issue(32'h0000_6000, RD_LINE, 8'd3, waited, acc, first_rdy);
    wait_ret(base + 4);
    #1;
    check("post_reset_beats", 64'(ret_seen - base), 64'd4);

    repeat (3) @(posedge clk);
    #1;
    check("r_q_empty", 64'(r_q.size()), 64'd0);
    check("ar_q_empty", 64'(ar_q.size()), 64'd0);
    check("aw_q_empty", 64'(aw_q.size()), 64'd0);
    check("w_q_empty", 64'(w_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
